// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared definitions for the data-memory arbiter.
//   state_t   - arbiter FSM encoding (IDLE/ISSUE/WAIT/ACK)
//   PORT_CPU  - port index of the CPU load/store stage
//   PORT_IO   - port index of the UART/IO loader
//   addr_bad  - flags misaligned or out-of-range byte addresses
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_IO  = 1'b1;

  // A byte address is bad when it is not word-aligned or lies at or beyond
  // depth*4. The limit is widened to 34 bits so depth*4 cannot wrap.
  function automatic logic addr_bad(input logic [31:0] addr, input int unsigned depth);
    logic [33:0] limit;
    limit = 34'(depth) * 34'd4;
    return (addr[1:0] != 2'b00) || ({2'b00, addr} >= limit);
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: combinational two-way round-robin picker.
//   req  [1:0] in  - request per port
//   last       in  - index of the port granted most recently
//   gnt  [1:0] out - one-hot grant (zero when nothing is requested)
// On a tie the port that did not win last time is granted.
module rr_pick2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (last == PORT_IO) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data memory between the CPU (port 0) and the
// IO loader (port 1) with round-robin fairness.
//   clk, rst (async, active low)
//   pN_req/we/addr/wdata in  - request and command, held until pN_ack
//   pN_ack/err/rdata     out - completion pulse, error flag, read data
//   mRead, mWrite        out - one-cycle memory strobes
//   addr_in, write_data  out - memory address / write data (held)
//   m_rdata              in  - memory read data, RD_LAT cycles after mRead
//   busy                 out - high whenever the FSM is not IDLE
//   dbg_state            out - current FSM state for observation
// Handshake: a requester raises pN_req with a stable command and keeps it
// until pN_ack pulses for one cycle; arbitration happens only in IDLE, so a
// request raised during a transaction waits for the next IDLE cycle.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int RD_LAT      = 1,
  parameter int DEPTH_WORDS = 16384
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_ack,
  output logic        p0_err,
  output logic [31:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_ack,
  output logic        p1_err,
  output logic [31:0] p1_rdata,
  output logic        mRead,
  output logic        mWrite,
  output logic [31:0] addr_in,
  output logic [31:0] write_data,
  input  logic [31:0] m_rdata,
  output logic        busy,
  output state_t      dbg_state
);

  localparam int CNT_W = $clog2(RD_LAT + 1);

  state_t             state_q, state_d;
  logic               cmd_we, cmd_port, cmd_err;
  logic               last_grant;
  logic [CNT_W-1:0]   wait_cnt;

  logic [1:0]         gnt;
  logic               any_gnt;
  logic               sel_port;
  logic               sel_we;
  logic [31:0]        sel_addr;
  logic [31:0]        sel_wdata;
  logic               sel_bad;

  rr_pick2 u_pick (
    .req  ({p1_req, p0_req}),
    .last (last_grant),
    .gnt  (gnt)
  );

  assign any_gnt   = |gnt;
  assign sel_port  = gnt[1];
  assign sel_we    = sel_port ? p1_we    : p0_we;
  assign sel_addr  = sel_port ? p1_addr  : p0_addr;
  assign sel_wdata = sel_port ? p1_wdata : p0_wdata;
  assign sel_bad   = addr_bad(sel_addr, DEPTH_WORDS);

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_gnt) state_d = sel_bad ? ACK : ISSUE;
      ISSUE:   state_d = cmd_we ? ACK : WAIT;
      WAIT:    if (wait_cnt == '0) state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode straight from the state register so an asynchronous
  // reset drops strobes, acks and busy in the same cycle.
  assign mWrite    = (state_q == ISSUE) &&  cmd_we;
  assign mRead     = (state_q == ISSUE) && !cmd_we;
  assign busy      = (state_q != IDLE);
  assign p0_ack    = (state_q == ACK) && (cmd_port == PORT_CPU);
  assign p1_ack    = (state_q == ACK) && (cmd_port == PORT_IO);
  assign p0_err    = p0_ack && cmd_err;
  assign p1_err    = p1_ack && cmd_err;
  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cmd_we     <= 1'b0;
      cmd_port   <= PORT_CPU;
      cmd_err    <= 1'b0;
      last_grant <= PORT_IO;
      wait_cnt   <= '0;
      addr_in    <= '0;
      write_data <= '0;
      p0_rdata   <= '0;
      p1_rdata   <= '0;
    end else begin
      state_q <= state_d;

      if (state_q == IDLE && any_gnt) begin
        cmd_we     <= sel_we;
        cmd_port   <= sel_port;
        cmd_err    <= sel_bad;
        last_grant <= sel_port;
        if (!sel_bad) begin
          // Memory only ever sees the latched command.
          addr_in    <= sel_addr;
          write_data <= sel_wdata;
        end else if (sel_port == PORT_IO) begin
          p1_rdata <= '0;
        end else begin
          p0_rdata <= '0;
        end
      end

      if (state_q == ISSUE) begin
        wait_cnt <= CNT_W'(RD_LAT - 1);
      end

      if (state_q == WAIT) begin
        if (wait_cnt == '0) begin
          if (cmd_port == PORT_IO) p1_rdata <= m_rdata;
          else                     p0_rdata <= m_rdata;
        end else begin
          wait_cnt <= wait_cnt - CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int RD_LAT      = 1;
  localparam int DEPTH_WORDS = 16384;

  logic        clk;
  logic        rst;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_ack, p0_err, p1_ack, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mRead, mWrite;
  logic [31:0] addr_in, write_data, m_rdata;
  logic        busy;
  state_t      dbg_state;

  dmem_arbiter #(.RD_LAT(RD_LAT), .DEPTH_WORDS(DEPTH_WORDS)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
    .mRead(mRead), .mWrite(mWrite), .addr_in(addr_in), .write_data(write_data),
    .m_rdata(m_rdata), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_bad = 0;
  // strobe entry: {we, addr, wdata, cycle}
  logic [96:0] exp_sq[$];
  // ack entry: {port, err, rdata, cycle}
  logic [65:0] exp_aq[$];
  logic [31:0] mem [0:63];
  int t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic push_s(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input int c);
    exp_sq.push_back({we, addr, wdata, 32'(c)});
  endtask

  task automatic push_a(input logic port, input logic err, input logic [31:0] rdata, input int c);
    exp_aq.push_back({port, err, rdata, 32'(c)});
  endtask

  // ---------------- memory model ----------------
  task automatic mem_model();
    for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE_0000 + 32'(i);
    m_rdata = '0;
    forever begin
      @(posedge clk);
      if (mWrite) mem[addr_in[7:2]] = write_data;
      if (mRead)  m_rdata <= mem[addr_in[7:2]];
    end
  endtask

  // ---------------- monitor ----------------
  task automatic check_ack(input logic port);
    logic [65:0] e;
    if (exp_aq.size() == 0) begin
      n_vec++; n_bad++;
      $display("FAIL unexpected_ack port %0d at cycle %0d: got ack, expected none", port, cyc);
    end else begin
      e = exp_aq.pop_front();
      chk("ack_port",  {31'b0, port}, {31'b0, e[65]});
      chk("ack_err",   {31'b0, port ? p1_err : p0_err}, {31'b0, e[64]});
      chk("ack_rdata", port ? p1_rdata : p0_rdata, e[63:32]);
      chk("ack_cycle", 32'(cyc), e[31:0]);
    end
  endtask

  task automatic monitor();
    logic [96:0] s;
    forever begin
      @(negedge clk);
      if (mRead || mWrite) begin
        chk("strobe_excl", {31'b0, mRead && mWrite}, 32'd0);
        if (exp_sq.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL unexpected_strobe at cycle %0d: got addr %h, expected no strobe", cyc, addr_in);
        end else begin
          s = exp_sq.pop_front();
          chk("strobe_we",   {31'b0, mWrite}, {31'b0, s[96]});
          chk("strobe_addr", addr_in, s[95:64]);
          if (s[96]) chk("strobe_wdata", write_data, s[63:32]);
          chk("strobe_cycle", 32'(cyc), s[31:0]);
        end
      end
      if (p0_ack || p1_ack) begin
        chk("ack_overlap", {31'b0, p0_ack && p1_ack}, 32'd0);
        if (p0_ack) check_ack(1'b0);
        if (p1_ack) check_ack(1'b1);
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic port, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic keep);
    logic got;
    got = 1'b0;
    if (!port) begin
      p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wdata;
    end else begin
      p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wdata;
    end
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); #1;
      got = port ? p1_ack : p0_ack;
    end
    if (!got) begin
      n_vec++; n_bad++;
      $display("FAIL ack_timeout port %0d addr %h: got no ack in 40 cycles, expected ack", port, addr);
    end
    if (!keep) begin
      if (!port) p0_req = 1'b0;
      else       p1_req = 1'b0;
    end
  endtask

  task automatic sync();
    @(posedge clk); #1;
    t = cyc;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] rd_addr [0:2];
  logic [31:0] rd_data [0:2];

  initial begin
    rst = 1'b0;
    p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
    p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
    fork
      mem_model();
      monitor();
    join_none

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_busy",   {31'b0, busy}, 32'd0);
    chk("rst_strobe", {30'b0, mRead, mWrite}, 32'd0);
    chk("rst_ack",    {30'b0, p0_ack, p1_ack}, 32'd0);
    chk("rst_addr",   addr_in, 32'd0);
    chk("rst_wdata",  write_data, 32'd0);
    chk("rst_rdata",  p0_rdata | p1_rdata, 32'd0);
    chk("rst_state",  {30'b0, dbg_state}, {30'b0, IDLE});
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);

    // Port 0 write, then read-back
    sync();
    push_s(1'b1, 32'h10, 32'h1234_5678, t + 1);
    push_a(1'b0, 1'b0, 32'h0, t + 2);
    drive(1'b0, 1'b1, 32'h10, 32'h1234_5678, 1'b0);
    repeat (2) @(posedge clk);
    sync();
    push_s(1'b0, 32'h10, 32'h0, t + 1);
    push_a(1'b0, 1'b0, 32'h1234_5678, t + 2 + RD_LAT);
    drive(1'b0, 1'b0, 32'h10, 32'h0, 1'b0);

    // Contention straight after reset: port 0 wins the first tie
    pulse_reset();
    sync();
    push_s(1'b1, 32'h20, 32'hAABB_CCDD, t + 1);
    push_a(1'b0, 1'b0, 32'h0, t + 2);
    push_s(1'b0, 32'h20, 32'h0, t + 4);
    push_a(1'b1, 1'b0, 32'hAABB_CCDD, t + 5 + RD_LAT);
    fork
      drive(1'b0, 1'b1, 32'h20, 32'hAABB_CCDD, 1'b0);
      drive(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
    join
    repeat (2) @(posedge clk);

    // Fairness: both ports keep requesting, grants alternate 0,1,0,1,0,1
    rd_addr[0] = 32'h10; rd_data[0] = 32'h1234_5678;
    rd_addr[1] = 32'h20; rd_data[1] = 32'hAABB_CCDD;
    rd_addr[2] = 32'h40; rd_data[2] = 32'h0A0A_0001;
    sync();
    for (int k = 0; k < 3; k++) begin
      push_s(1'b1, 32'h40 + 32'(4*k), 32'h0A0A_0001 + 32'(k), t + 7*k + 1);
      push_a(1'b0, 1'b0, 32'h0, t + 7*k + 2);
      push_s(1'b0, rd_addr[k], 32'h0, t + 7*k + 4);
      push_a(1'b1, 1'b0, rd_data[k], t + 7*k + 5 + RD_LAT);
    end
    fork
      for (int k = 0; k < 3; k++)
        drive(1'b0, 1'b1, 32'h40 + 32'(4*k), 32'h0A0A_0001 + 32'(k), k < 2);
      for (int j = 0; j < 3; j++)
        drive(1'b1, 1'b0, rd_addr[j], 32'h0, j < 2);
    join
    repeat (2) @(posedge clk);

    // Error accesses: misaligned, first out-of-range word, last legal word
    sync();
    push_a(1'b1, 1'b1, 32'h0, t + 1);
    drive(1'b1, 1'b0, 32'h13, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    sync();
    push_a(1'b1, 1'b1, 32'h0, t + 1);
    drive(1'b1, 1'b0, 32'(DEPTH_WORDS*4), 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    sync();
    push_s(1'b0, 32'(DEPTH_WORDS*4 - 4), 32'h0, t + 1);
    push_a(1'b1, 1'b0, 32'hC0DE_003F, t + 2 + RD_LAT);
    drive(1'b1, 1'b0, 32'(DEPTH_WORDS*4 - 4), 32'h0, 1'b0);
    repeat (2) @(posedge clk);

    // Reset during WAIT: everything drops at once, no ack
    sync();
    push_s(1'b0, 32'h10, 32'h0, t + 1);
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h10; p0_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_state_wait", {30'b0, dbg_state}, {30'b0, WAIT});
    rst = 1'b0;
    #1;
    chk("mid_busy",   {31'b0, busy}, 32'd0);
    chk("mid_strobe", {30'b0, mRead, mWrite}, 32'd0);
    chk("mid_ack",    {30'b0, p0_ack, p1_ack}, 32'd0);
    chk("mid_addr",   addr_in, 32'd0);
    p0_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    sync();
    push_s(1'b0, 32'h20, 32'h0, t + 1);
    push_a(1'b0, 1'b0, 32'hAABB_CCDD, t + 2 + RD_LAT);
    drive(1'b0, 1'b0, 32'h20, 32'h0, 1'b0);

    repeat (5) @(posedge clk);
    chk("strobe_queue_left", 32'(exp_sq.size()), 32'd0);
    chk("ack_queue_left",    32'(exp_aq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
